// File: rtl/kf76489_pkg.sv
// Shared constants and types for the tone bank: amplitude table, amplitude
// width and the register field selector used by the write decode.
package kf76489_pkg;

    localparam int AMP_W = 6;

    // Attenuation-indexed output level; entry 15 is silence.
    localparam logic [15:0][AMP_W-1:0] AMP_TABLE = {
        6'd0,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd8,  6'd10,
        6'd13, 6'd16, 6'd20, 6'd25, 6'd32, 6'd40, 6'd50, 6'd63
    };

    typedef enum logic [1:0] {
        FIELD_FREQ_H,
        FIELD_FREQ_L,
        FIELD_ATTEN
    } field_e;

    function automatic logic [AMP_W-1:0] amp_lookup(input logic [3:0] atten);
        return AMP_TABLE[atten];
    endfunction

endpackage

// File: rtl/kf76489_tone_channel.sv
// One tone channel: period/attenuation registers, down-counting divider,
// square-wave tone bit, toggle pulse and amplitude output.
module kf76489_tone_channel
    import kf76489_pkg::*;
#(
    parameter int FREQ_WIDTH  = 10,
    parameter int ZERO_IS_MAX = 0,
    parameter int PHASE_RESET = 0
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             clock_enable_i,
    input  logic             wr_en_i,
    input  field_e           wr_field_i,
    input  logic [7:0]       wr_data_i,
    output logic             cycle_o,
    output logic [AMP_W-1:0] analog_o
);

    localparam int HI_BITS = FREQ_WIDTH - 6;

    logic [FREQ_WIDTH-1:0] freq_q, freq_d;
    logic [3:0]            atten_q, atten_d;
    logic [FREQ_WIDTH-1:0] div_q, div_d;
    logic                  tone_q, tone_d;
    logic                  cycle_q, cycle_d;
    logic                  restart;

    // Reload value is P-1; a zero period maps to either 1 or 2^FREQ_WIDTH,
    // and the latter's P-1 is simply all-ones.
    function automatic logic [FREQ_WIDTH-1:0] period_m1(input logic [FREQ_WIDTH-1:0] f);
        if (f == '0) begin
            return (ZERO_IS_MAX != 0) ? '1 : '0;
        end
        return f - 1'b1;
    endfunction

    // Field writes, then divider advance; a phase restart takes precedence
    // over a terminal count landing in the same cycle.
    always_comb begin
        freq_d  = freq_q;
        atten_d = atten_q;
        div_d   = div_q;
        tone_d  = tone_q;
        cycle_d = 1'b0;
        restart = 1'b0;

        if (wr_en_i) begin
            case (wr_field_i)
                FIELD_FREQ_H: begin
                    freq_d[FREQ_WIDTH-1:6] = wr_data_i[7 -: HI_BITS];
                    restart                = (PHASE_RESET != 0);
                end
                FIELD_FREQ_L: freq_d[5:0] = wr_data_i[7:2];
                FIELD_ATTEN:  atten_d     = wr_data_i[7:4];
                default: ;
            endcase
        end

        if (restart) begin
            div_d  = period_m1(freq_d);
            tone_d = 1'b0;
        end else if (clock_enable_i) begin
            if (div_q == '0) begin
                // Reload from the frequency in force before any same-cycle write.
                div_d   = period_m1(freq_q);
                tone_d  = ~tone_q;
                cycle_d = 1'b1;
            end else begin
                div_d = div_q - 1'b1;
            end
        end
    end

    // Channel state register; reset leaves the divider one step from terminal.
    always_ff @(posedge clock) begin
        if (reset) begin
            freq_q  <= '0;
            atten_q <= 4'hF;
            div_q   <= FREQ_WIDTH'(1);
            tone_q  <= 1'b0;
            cycle_q <= 1'b0;
        end else begin
            freq_q  <= freq_d;
            atten_q <= atten_d;
            div_q   <= div_d;
            tone_q  <= tone_d;
            cycle_q <= cycle_d;
        end
    end

    assign cycle_o  = cycle_q;
    assign analog_o = tone_q ? amp_lookup(atten_q) : '0;

endmodule

// File: rtl/kf76489_tone_bank.sv
// Bank of square-wave tone channels sharing one write port, with a
// registered mix of all channel amplitudes.
module kf76489_tone_bank
    import kf76489_pkg::*;
#(
    parameter int  CHANNELS    = 3,
    parameter int  FREQ_WIDTH  = 10,
    parameter int  ZERO_IS_MAX = 0,
    parameter int  PHASE_RESET = 0,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int MIX_W       = AMP_W + $clog2(CHANNELS + 1)
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clock_enable,
    input  logic [7:0]                    internal_data_bus,
    input  logic [CH_W-1:0]               write_channel,
    input  logic                          write_frequency_h,
    input  logic                          write_frequency_l,
    input  logic                          write_attenuation,
    output logic [CHANNELS-1:0]           cycle_out,
    output logic [CHANNELS-1:0][AMP_W-1:0] analog_out,
    output logic [MIX_W-1:0]              mix_out
);

    field_e             wr_field;
    logic               wr_any;
    logic [MIX_W-1:0]   mix_q, mix_d;

    // Collapse simultaneous strobes to one field, high beats low beats attenuation.
    always_comb begin
        wr_any   = write_frequency_h | write_frequency_l | write_attenuation;
        wr_field = FIELD_ATTEN;
        if (write_frequency_h) begin
            wr_field = FIELD_FREQ_H;
        end else if (write_frequency_l) begin
            wr_field = FIELD_FREQ_L;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        // Out-of-range channel indices match no instance and are dropped.
        logic wr_en;
        assign wr_en = wr_any && (write_channel == CH_W'(n));

        kf76489_tone_channel #(
            .FREQ_WIDTH  (FREQ_WIDTH),
            .ZERO_IS_MAX (ZERO_IS_MAX),
            .PHASE_RESET (PHASE_RESET)
        ) u_ch (
            .clock          (clock),
            .reset          (reset),
            .clock_enable_i (clock_enable),
            .wr_en_i        (wr_en),
            .wr_field_i     (wr_field),
            .wr_data_i      (internal_data_bus),
            .cycle_o        (cycle_out[n]),
            .analog_o       (analog_out[n])
        );
    end

    // Sum of all channel amplitudes; MIX_W is wide enough that no saturation is needed.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_d = mix_d + MIX_W'(analog_out[i]);
        end
    end

    // Mixer output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix_out = mix_q;

endmodule

// File: tb/tb_kf76489_tone_bank.sv
// Bench for the tone bank: two configurations (defaults, and a small
// 2-channel / 7-bit / zero-is-max / phase-reset bank) run side by side
// against a cycle-level behavioural model of period, phase and amplitude.
module tb_kf76489_tone_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration A: defaults
    logic             rst_a, ce_a, h_a, l_a, at_a;
    logic [7:0]       data_a;
    logic [1:0]       wch_a;
    logic [2:0]       cyc_a;
    logic [2:0][5:0]  an_a;
    logic [7:0]       mix_a;

    // Configuration B: CHANNELS=2, FREQ_WIDTH=7, ZERO_IS_MAX=1, PHASE_RESET=1
    logic             rst_b, ce_b, h_b, l_b, at_b;
    logic [7:0]       data_b;
    logic [0:0]       wch_b;
    logic [1:0]       cyc_b;
    logic [1:0][5:0]  an_b;
    logic [7:0]       mix_b;

    kf76489_tone_bank dut_a (
        .clock(clk), .reset(rst_a), .clock_enable(ce_a),
        .internal_data_bus(data_a), .write_channel(wch_a),
        .write_frequency_h(h_a), .write_frequency_l(l_a), .write_attenuation(at_a),
        .cycle_out(cyc_a), .analog_out(an_a), .mix_out(mix_a)
    );

    kf76489_tone_bank #(
        .CHANNELS(2), .FREQ_WIDTH(7), .ZERO_IS_MAX(1), .PHASE_RESET(1)
    ) dut_b (
        .clock(clk), .reset(rst_b), .clock_enable(ce_b),
        .internal_data_bus(data_b), .write_channel(wch_b),
        .write_frequency_h(h_b), .write_frequency_l(l_b), .write_attenuation(at_b),
        .cycle_out(cyc_b), .analog_out(an_b), .mix_out(mix_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int amp_tab[16] = '{63, 50, 40, 32, 25, 20, 16, 13, 10, 8, 6, 5, 4, 3, 2, 0};

    int m_freq [2][3];
    int m_att  [2][3];
    int m_rem  [2][3];   // enabled cycles until the next toggle
    bit m_tone [2][3];
    bit m_cyc  [2][3];
    int m_mix  [2];

    function automatic int nch(input int d); return (d == 0) ? 3 : 2; endfunction
    function automatic int fw (input int d); return (d == 0) ? 10 : 7; endfunction
    function automatic bit zim(input int d); return d != 0; endfunction
    function automatic bit pr (input int d); return d != 0; endfunction

    function automatic int eff_period(input int d, input int f);
        if (f == 0) return zim(d) ? (1 << fw(d)) : 1;
        return f;
    endfunction

    function automatic int level(input int d, input int c);
        return m_tone[d][c] ? amp_tab[m_att[d][c]] : 0;
    endfunction

    task automatic model_step(input int d, input bit rst, input bit ce, input logic [7:0] data,
                              input int ch, input bit h, input bit l, input bit a);
        int sum;
        if (rst) begin
            for (int c = 0; c < 3; c++) begin
                m_freq[d][c] = 0; m_att[d][c] = 15; m_rem[d][c] = 2;
                m_tone[d][c] = 0; m_cyc[d][c] = 0;
            end
            m_mix[d] = 0;
            return;
        end
        sum = 0;
        for (int c = 0; c < nch(d); c++) sum += level(d, c);
        m_mix[d] = sum;
        for (int c = 0; c < nch(d); c++) begin
            bit tgt;
            int nf, na;
            tgt = (ch == c) && (h || l || a);
            nf  = m_freq[d][c];
            na  = m_att[d][c];
            m_cyc[d][c] = 0;
            if (tgt) begin
                if (h)      nf = ((int'(data) >> (14 - fw(d))) << 6) + (m_freq[d][c] % 64);
                else if (l) nf = (m_freq[d][c] / 64) * 64 + (int'(data) >> 2);
                else        na = int'(data) >> 4;
            end
            if (tgt && h && pr(d)) begin
                m_tone[d][c] = 0;
                m_rem[d][c]  = eff_period(d, nf);
            end else if (ce) begin
                m_rem[d][c]--;
                if (m_rem[d][c] == 0) begin
                    m_tone[d][c] = !m_tone[d][c];
                    m_cyc[d][c]  = 1;
                    m_rem[d][c]  = eff_period(d, m_freq[d][c]);
                end
            end
            m_freq[d][c] = nf;
            m_att[d][c]  = na;
        end
    endtask

    function automatic logic [31:0] exp_cyc(input int d);
        logic [31:0] v = 0;
        for (int c = 0; c < nch(d); c++) if (m_cyc[d][c]) v |= 32'(1) << c;
        return v;
    endfunction

    function automatic logic [31:0] exp_an(input int d);
        logic [31:0] v = 0;
        for (int c = 0; c < nch(d); c++) v |= 32'(level(d, c)) << (6 * c);
        return v;
    endfunction

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(0, rst_a, ce_a, data_a, int'(wch_a), h_a, l_a, at_a);
        model_step(1, rst_b, ce_b, data_b, int'(wch_b), h_b, l_b, at_b);
        @(negedge clk);
        check("cyc_a", cyc_a, exp_cyc(0));
        check("an_a",  an_a,  exp_an(0));
        check("mix_a", mix_a, m_mix[0]);
        check("cyc_b", cyc_b, exp_cyc(1));
        check("an_b",  an_b,  exp_an(1));
        check("mix_b", mix_b, m_mix[1]);
    endtask

    // kind: 0 = high field, 1 = low field, 2 = attenuation
    task automatic wr(input int d, input int ch, input int kind, input logic [7:0] data);
        if (d == 0) begin
            data_a = data; wch_a = ch[1:0];
            h_a = (kind == 0); l_a = (kind == 1); at_a = (kind == 2);
        end else begin
            data_b = data; wch_b = ch[0:0];
            h_b = (kind == 0); l_b = (kind == 1); at_b = (kind == 2);
        end
        tick();
        h_a = 0; l_a = 0; at_a = 0; h_b = 0; l_b = 0; at_b = 0;
    endtask

    function automatic logic pulse(input int d, input int ch);
        return (d == 0) ? cyc_a[ch] : cyc_b[ch];
    endfunction

    // Ticks until the channel's cycle_out is seen, bounded.
    task automatic wait_pulse(input int d, input int ch, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!pulse(d, ch) && n < 3000);
        check("pulse_seen", pulse(d, ch), 1);
    endtask

    int n;

    initial begin
        rst_a = 1; ce_a = 0; h_a = 0; l_a = 0; at_a = 0; data_a = 0; wch_a = 0;
        rst_b = 1; ce_b = 0; h_b = 0; l_b = 0; at_b = 0; data_b = 0; wch_b = 0;
        tick(); tick();
        rst_a = 0; rst_b = 0;
        check("rst_mix_a", mix_a, 0);
        check("rst_an_a",  an_a,  0);
        check("rst_cyc_b", cyc_b, 0);

        // Frequency 67, full amplitude on channel 0
        wr(0, 0, 0, 8'h10); wr(0, 0, 1, 8'h0C); wr(0, 0, 2, 8'h00);
        ce_a = 1;
        wait_pulse(0, 0, n);
        check("first_toggle", n, 2);
        check("an0_high", an_a[0], 63);
        wait_pulse(0, 0, n);
        check("period_67", n, 67);
        check("an0_low", an_a[0], 0);
        wait_pulse(0, 1, n);
        check("zero_is_one", n, 1);

        // Low write landing on terminal count
        for (int i = 0; i < 200 && m_rem[0][0] != 1; i++) tick();
        wr(0, 0, 1, 8'h00);
        check("tc_pulse", cyc_a[0], 1);
        wait_pulse(0, 0, n);
        check("tc_old_period", n, 67);
        wait_pulse(0, 0, n);
        check("tc_new_period", n, 64);

        // Zero period as 2^7 on config B
        ce_b = 1;
        wait_pulse(1, 0, n);
        wait_pulse(1, 0, n);
        check("zero_is_max", n, 128);

        // Phase restart on high write
        wr(1, 0, 2, 8'h00); wr(1, 0, 1, 8'h28); wr(1, 0, 0, 8'h00);
        wait_pulse(1, 0, n);
        if (!m_tone[1][0]) wait_pulse(1, 0, n);
        repeat (4) tick();
        wr(1, 0, 0, 8'h00);
        check("restart_tone", an_b[0], 0);
        check("restart_nopulse", cyc_b[0], 0);
        wait_pulse(1, 0, n);
        check("restart_period", n, 10);

        // Mixer sum and out-of-range channel
        ce_a = 0; rst_a = 1; tick(); rst_a = 0;
        wr(0, 0, 2, 8'h00); wr(0, 1, 2, 8'h20); wr(0, 2, 2, 8'hF0);
        ce_a = 1; tick(); tick(); ce_a = 0;
        check("amp_levels", an_a, {6'd0, 6'd40, 6'd63});
        tick();
        check("mix_103", mix_a, 103);
        for (int k = 0; k < 3; k++) wr(0, 3, k, 8'hFF);
        check("ch3_ignored", an_a, {6'd0, 6'd40, 6'd63});
        check("mix_held", mix_a, 103);

        // Reset mid-count, with writes and enable active
        wr(0, 0, 0, 8'h10);
        ce_a = 1;
        repeat (10) tick();
        rst_a = 1; h_a = 1; at_a = 1; data_a = 8'h00; wch_a = 0;
        tick();
        rst_a = 0; h_a = 0; at_a = 0;
        check("rst_cyc", cyc_a, 0);
        check("rst_an", an_a, 0);
        check("rst_mix", mix_a, 0);
        wait_pulse(0, 0, n);
        check("post_rst_toggle", n, 2);

        // Randomized traffic on both configurations
        for (int i = 0; i < 3000; i++) begin
            ce_a   = ($urandom_range(0, 3) != 0);
            rst_a  = ($urandom_range(0, 299) == 0);
            data_a = 8'($urandom);
            wch_a  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                h_a = 1'($urandom); l_a = 1'($urandom); at_a = 1'($urandom);
            end else begin
                h_a = 0; l_a = 0; at_a = 0;
            end
            ce_b   = ($urandom_range(0, 3) != 0);
            rst_b  = ($urandom_range(0, 299) == 0);
            data_b = 8'($urandom);
            wch_b  = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                h_b = 1'($urandom); l_b = 1'($urandom); at_b = 1'($urandom);
            end else begin
                h_b = 0; l_b = 0; at_b = 0;
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
